// File: rtl/mul_seq_if.sv
// mul_seq_if -- handshake and operand/result bundle for the sequential multiplier.
// The master side issues start/op/a/b and observes busy/done/result/flags.
interface mul_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic [1:0]  flags;

    modport master (
        output start, op, a, b,
        input  busy, done, result_lo, result_hi, flags
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result_lo, result_hi, flags
    );
endinterface

// File: rtl/mul_seq.sv
// mul_seq -- 32x32 radix-2 shift-add multiplier, one multiplier bit per cycle.
// Ops: 00 MUL (low word only), 01 UMULL, 10 SMULL, 11 behaves as UMULL.
// Optional feature macro: MUL_SEQ_SIGNED_EN. When undefined, op 10 runs as
// UMULL and no magnitude/negation hardware exists.
module mul_seq (
    input  logic       clk,
    input  logic       reset,
    mul_seq_if.slave   bus
);

    localparam int DATA_W = 32;
    localparam int PROD_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_p0;
    logic [5:0]          cnt_p0;
    logic [DATA_W-1:0]   mcand_p0;
    logic [PROD_W-1:0]   prod_p0;
    logic                is_mul_p0;
    logic                busy_p0;
    logic                done_p0;
    logic [DATA_W-1:0]   res_lo_p0;
    logic [DATA_W-1:0]   res_hi_p0;
    logic [1:0]          flags_p0;
`ifdef MUL_SEQ_SIGNED_EN
    logic                neg_p0;
`endif

    logic [DATA_W-1:0]   a_in;
    logic [DATA_W-1:0]   b_in;
    logic [DATA_W:0]     sum_c;
    logic [PROD_W-1:0]   step_c;
    logic [PROD_W-1:0]   final_c;
    logic [DATA_W-1:0]   lo_c;
    logic [DATA_W-1:0]   hi_c;
    logic [1:0]          flags_c;
`ifdef MUL_SEQ_SIGNED_EN
    logic                signed_req;
    logic                sign_in;

    // Absolute value of a two's-complement operand; 0x80000000 maps to itself,
    // which is the correct unsigned magnitude 2^31.
    function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v);
        logic signed [DATA_W-1:0] n;
        n = -v;
        return v[DATA_W-1] ? DATA_W'(n) : DATA_W'(v);
    endfunction

    // Two's-complement negation of the full-width product.
    function automatic logic [PROD_W-1:0] neg64(input logic [PROD_W-1:0] v);
        return ~v + PROD_W'(1);
    endfunction
`endif

    // Operand conditioning applied at acceptance: magnitudes and sign for SMULL.
    always_comb begin
`ifdef MUL_SEQ_SIGNED_EN
        signed_req = (bus.op == 2'b10);
        a_in       = signed_req ? mag(bus.a) : bus.a;
        b_in       = signed_req ? mag(bus.b) : bus.b;
        sign_in    = signed_req & (bus.a[DATA_W-1] ^ bus.b[DATA_W-1]);
`else
        a_in       = bus.a;
        b_in       = bus.b;
`endif
    end

    // One shift-add iteration: conditionally add multiplicand to the upper
    // half, then shift the 65-bit {carry, product} right by one.
    always_comb begin
        sum_c  = {1'b0, prod_p0[PROD_W-1:DATA_W]}
               + (prod_p0[0] ? {1'b0, mcand_p0} : {(DATA_W+1){1'b0}});
        step_c = {sum_c, prod_p0[DATA_W-1:1]};
`ifdef MUL_SEQ_SIGNED_EN
        final_c = neg_p0 ? neg64(step_c) : step_c;
`else
        final_c = step_c;
`endif
        lo_c    = final_c[DATA_W-1:0];
        hi_c    = is_mul_p0 ? {DATA_W{1'b0}} : final_c[PROD_W-1:DATA_W];
        // hi_c is zero for MUL, so a single 64-bit zero test covers both cases.
        flags_c = {(is_mul_p0 ? lo_c[DATA_W-1] : hi_c[DATA_W-1]),
                   ({hi_c, lo_c} == {PROD_W{1'b0}})};
    end

    // Control FSM with the iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0  <= IDLE;
            cnt_p0    <= 6'd0;
            mcand_p0  <= '0;
            prod_p0   <= '0;
            is_mul_p0 <= 1'b0;
            busy_p0   <= 1'b0;
            done_p0   <= 1'b0;
            res_lo_p0 <= '0;
            res_hi_p0 <= '0;
            flags_p0  <= 2'b00;
`ifdef MUL_SEQ_SIGNED_EN
            neg_p0    <= 1'b0;
`endif
        end else begin
            done_p0 <= 1'b0;
            case (state_p0)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_p0  <= CALC;
                        busy_p0   <= 1'b1;
                        cnt_p0    <= 6'd0;
                        mcand_p0  <= a_in;
                        prod_p0   <= {{DATA_W{1'b0}}, b_in};
                        is_mul_p0 <= (bus.op == 2'b00);
`ifdef MUL_SEQ_SIGNED_EN
                        neg_p0    <= sign_in;
`endif
                    end else begin
                        state_p0 <= IDLE;
                    end
                end
                CALC: begin
                    prod_p0 <= step_c;
                    cnt_p0  <= cnt_p0 + 6'd1;
                    if (cnt_p0 == 6'd31) begin
                        state_p0  <= DONE;
                        busy_p0   <= 1'b0;
                        done_p0   <= 1'b1;
                        res_lo_p0 <= lo_c;
                        res_hi_p0 <= hi_c;
                        flags_p0  <= flags_c;
                    end
                end
                default: begin
                    state_p0 <= IDLE;
                    busy_p0  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_p0;
    assign bus.done      = done_p0;
    assign bus.result_lo = res_lo_p0;
    assign bus.result_hi = res_hi_p0;
    assign bus.flags     = flags_p0;

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq -- directed and randomized checks of mul_seq against a plain
// arithmetic reference model.
module tb_mul_seq;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    logic [31:0] prev_lo;
    logic [31:0] prev_hi;
    logic [1:0]  prev_flags;

    mul_seq_if bus ();

    mul_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference product: plain arithmetic on the operation's meaning.
    function automatic logic [63:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] ua, ub, sa, sb, p;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'b00: begin
                p = ua * ub;
                return {32'd0, p[31:0]};
            end
`ifdef MUL_SEQ_SIGNED_EN
            2'b10: return sa * sb;
`endif
            default: return ua * ub;
        endcase
    endfunction

    function automatic logic [1:0] model_flags(input logic [1:0] op, input logic [63:0] r);
        if (op == 2'b00) return {r[31], (r[31:0] == 32'd0)};
        return {r[63], (r == 64'd0)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation at the current negedge and follow it to its done cycle.
    // Mid-CALC, start/op/a/b are scrambled when noisy is set.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit noisy);
        logic [63:0] r;
        logic [1:0]  f;
        r = model(op, a, b);
        f = model_flags(op, r);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        for (int i = 1; i <= 32; i++) begin
            check("busy_calc", 64'(bus.busy), 64'd1);
            check("done_calc", 64'(bus.done), 64'd0);
            if (i == 1 || i == 32)
                check("hold_calc", {bus.result_hi, bus.result_lo}, {prev_hi, prev_lo});
            if (noisy) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.op    = 2'($urandom_range(0, 3));
                bus.a     = $urandom;
                bus.b     = $urandom;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        check("done_pulse", 64'(bus.done), 64'd1);
        check("busy_done",  64'(bus.busy), 64'd0);
        check("result",     {bus.result_hi, bus.result_lo}, r);
        check("flags",      64'(bus.flags), 64'(f));
        prev_lo    = r[31:0];
        prev_hi    = r[63:32];
        prev_flags = f;
        bus.start  = 1'b0;
    endtask

    // One idle cycle after done: back to IDLE with results held.
    task automatic idle_cycle();
        bus.start = 1'b0;
        @(negedge clk);
        check("busy_idle",   64'(bus.busy), 64'd0);
        check("done_idle",   64'(bus.done), 64'd0);
        check("hold_idle",   {bus.result_hi, bus.result_lo}, {prev_hi, prev_lo});
        check("flags_idle",  64'(bus.flags), 64'(prev_flags));
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        prev_lo    = '0;
        prev_hi    = '0;
        prev_flags = 2'b00;
        bus.start  = 1'b1;
        bus.op     = 2'b01;
        bus.a      = 32'hDEAD_BEEF;
        bus.b      = 32'h1234_5678;
        reset      = 1'b1;

        // Reset with start asserted: reset wins.
        @(negedge clk);
        @(negedge clk);
        check("rst_busy",  64'(bus.busy), 64'd0);
        check("rst_done",  64'(bus.done), 64'd0);
        check("rst_res",   {bus.result_hi, bus.result_lo}, 64'd0);
        check("rst_flags", 64'(bus.flags), 64'd0);
        reset     = 1'b0;
        bus.start = 1'b0;
        idle_cycle();

        // Directed cases.
        run_op(2'b00, 32'd7, 32'd6, 1'b1);
        check("mul_7x6", {bus.result_hi, bus.result_lo, 30'd0, bus.flags},
              {32'd0, 32'h0000_002A, 32'd0});
        idle_cycle();
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check("umull_max", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFE_0000_0001);
        check("umull_max_flags", 64'(bus.flags), 64'd2);
        idle_cycle();
        run_op(2'b10, 32'hFFFF_FFFD, 32'd5, 1'b1);
`ifdef MUL_SEQ_SIGNED_EN
        check("smull_m3x5", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        check("smull_m3x5_flags", 64'(bus.flags), 64'd2);
`else
        check("smull_m3x5", {bus.result_hi, bus.result_lo}, 64'h0000_0004_FFFF_FFF1);
        check("smull_m3x5_flags", 64'(bus.flags), 64'd0);
`endif
        idle_cycle();
        run_op(2'b10, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(2'b11, 32'h0001_0000, 32'h0001_0000, 1'b1);
        check("rsvd_as_umull", {bus.result_hi, bus.result_lo}, 64'h0000_0001_0000_0000);

        // Start held high: back-to-back with no idle cycle, mid-CALC noise ignored.
        for (int k = 0; k < 3; k++)
            run_op(2'($urandom_range(0, 3)), $urandom, $urandom, 1'b1);
        idle_cycle();

        // Reset at CALC cycle 10 aborts with no done pulse.
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'h1234_5678;
        bus.b     = 32'h9ABC_DEF0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i < 10; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy",  64'(bus.busy), 64'd0);
        check("abort_done",  64'(bus.done), 64'd0);
        check("abort_res",   {bus.result_hi, bus.result_lo}, 64'd0);
        check("abort_flags", 64'(bus.flags), 64'd0);
        prev_lo    = '0;
        prev_hi    = '0;
        prev_flags = 2'b00;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            check("abort_no_done", 64'(bus.done), 64'd0);
        end
        run_op(2'b00, 32'd0, 32'd9, 1'b0);
        check("mul_zero_flags", 64'(bus.flags), 64'd1);
        idle_cycle();

        // Randomized operations, randomly chained or separated by idle cycles.
        for (int k = 0; k < 12; k++) begin
            run_op(2'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Module SHALL have no parameters; operand width is fixed at 32 bits, product width at 64 bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a multiply; sampled on rising edge.
REQ-005 op  input  2  operation: 00 MUL, 01 UMULL, 10 SMULL, 11 reserved.
REQ-006 a  input  32  multiplicand; sampled only when start is accepted.
REQ-007 b  input  32  multiplier; sampled only when start is accepted.
REQ-008 busy  output  1  high while a multiply is in progress.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 result_lo  output  32  product bits [31:0].
REQ-011 result_hi  output  32  product bits [63:32]; zero for MUL.
REQ-012 flags  output  2  {N,Z} of the result.

Function
REQ-013 FSM SHALL have three states: IDLE, CALC, DONE.
REQ-014 IDLE->CALC and DONE->CALC SHALL occur when start=1; start in CALC SHALL be ignored, with no queueing.
REQ-015 On acceptance, a, b and op SHALL be latched; for SMULL each operand SHALL be replaced by its magnitude, and the sign = a[31]^b[31] SHALL be latched.
REQ-016 CALC SHALL run exactly 32 cycles of radix-2 shift-add, one multiplier bit per cycle, with a 6-bit iteration counter.
REQ-017 Latency: start accepted at the edge ending cycle T -> busy=1 in cycles T+1..T+32 -> done=1 in cycle T+33 only.
REQ-018 Result registers SHALL update only at the CALC->DONE edge, then hold until the next CALC->DONE edge.
REQ-019 For SMULL with sign=1, the 64-bit product SHALL be two's-complement negated before it is registered.
REQ-020 MUL SHALL register product[31:0] in result_lo and force result_hi=0.
REQ-021 Reserved op 11 SHALL execute as UMULL.
REQ-022 N SHALL be result_lo[31] for MUL and result_hi[31] otherwise.
REQ-023 Z SHALL be 1 iff result_lo==0 for MUL, and iff the full 64-bit result==0 otherwise.
REQ-024 DONE->IDLE SHALL occur when start=0; DONE->CALC with start=1 gives back-to-back operation with no idle cycle.
REQ-025 busy SHALL be 0 in IDLE and DONE; done SHALL be 0 in IDLE and CALC.
REQ-026 Operand changes on a or b during CALC SHALL NOT affect the result.

Reset
REQ-027 reset=1 at any edge SHALL force IDLE and clear all outputs: busy=0, done=0, result_lo=0, result_hi=0, flags=00.
REQ-028 reset SHALL also clear the counter and all internal registers.
REQ-029 reset SHALL take priority over start.
REQ-030 Reset during CALC SHALL abort the operation with no done pulse.

Configuration
REQ-031 Macro MUL_SEQ_SIGNED_EN defined: op 10 SHALL perform a signed SMULL per REQ-015 and REQ-019.
REQ-032 Macro MUL_SEQ_SIGNED_EN undefined: op 10 SHALL execute as UMULL; the magnitude and negation logic SHALL NOT be synthesized. Latency and interface are unchanged.

Verification
REQ-033 MUL a=7, b=6 -> done at T+33, result_lo=0x0000002A, result_hi=0, flags=00.
REQ-034 UMULL a=b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, flags=10.
REQ-035 SMULL a=0xFFFFFFFD (-3), b=5 -> with MUL_SEQ_SIGNED_EN: 0xFFFFFFFF_FFFFFFF1, flags=10; without: 0x00000004_FFFFFFF1, flags=00.
REQ-036 SMULL a=b=0x80000000 with MUL_SEQ_SIGNED_EN -> 0x40000000_00000000, flags=00.
REQ-037 Start held high continuously -> done pulses every 33 cycles with no lost operation; start pulses injected mid-CALC are ignored.
REQ-038 Reset asserted at CALC cycle 10 -> next cycle busy=0, outputs zero, no done; a new start then completes normally; MUL a=0, b=9 -> flags=01.
